// File: rtl/organ_note_sequencer.sv
// organ_note_sequencer: picks divider count and tone gate from live switches or a stored 16-step pattern
module organ_note_sequencer #(
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic        inclk,
  input  logic        Reset_n,
  input  logic [7:0]  note_sw,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [3:0]  seq_len,
  input  logic        loop,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] div_clk_count,
  output logic        tone_en,
  output logic [3:0]  step_idx,
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_PLAY = 2'd2;
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [31:0] NOTE_TAB [8] = '{32'd47800, 32'd42588, 32'd37935, 32'd35816,
                                           32'd31927, 32'd28408, 32'd25328, 32'd23900};
  logic [1:0]    state;
  logic [7:0]    ram [16];
  logic [7:0]    entry;
  logic [7:0]    rd_data;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    dur_cnt;
  logic [2:0]    sw_note;
  logic          tick_last, step_end;
  assign rd_data   = ram[step_idx];
  assign tick_last = tick_cnt == TW'(TICK_CYCLES - 1);
  assign step_end  = tick_last && dur_cnt == entry[3:0];
  assign busy      = state != ST_IDLE;
  // lowest set switch wins
  always_comb begin
    sw_note = 3'd0;
    for (int i = 7; i >= 0; i--) if (note_sw[i]) sw_note = 3'(i);
  end
  // pattern RAM; a LOAD in the same cycle as a write sees the old entry
  always_ff @(posedge inclk or negedge Reset_n) begin
    if (!Reset_n) for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
    else if (wr_en) ram[wr_addr] <= wr_data;
  end
  // sequencer FSM and registered divider outputs
  always_ff @(posedge inclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      entry         <= 8'h00;
      tick_cnt      <= '0;
      dur_cnt       <= 4'd0;
      step_idx      <= 4'd0;
      div_clk_count <= 32'd0;
      tone_en       <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        tone_en <= |note_sw;
        if (|note_sw) div_clk_count <= NOTE_TAB[sw_note];
        if (start && !stop) begin
          state    <= ST_LOAD;
          step_idx <= 4'd0;
        end
      end else if (stop) begin
        state   <= ST_IDLE;
        tone_en <= 1'b0;
      end else if (state == ST_LOAD) begin
        entry         <= rd_data;
        tick_cnt      <= '0;
        dur_cnt       <= 4'd0;
        div_clk_count <= NOTE_TAB[rd_data[6:4]];
        tone_en       <= !rd_data[7];
        state         <= ST_PLAY;
      end else begin
        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
        if (tick_last) dur_cnt <= dur_cnt + 4'd1;
        if (step_end) begin
          if (step_idx < seq_len) begin
            step_idx <= step_idx + 4'd1;
            state    <= ST_LOAD;
          end else if (loop) begin
            step_idx <= 4'd0;
            state    <= ST_LOAD;
          end else begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            tone_en <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_organ_note_sequencer.sv
// tb_organ_note_sequencer: directed checks of live, pattern, loop, stop, write-race and reset behaviour
module tb_organ_note_sequencer;
  logic        inclk = 1'b0;
  logic        Reset_n;
  logic [7:0]  note_sw;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  seq_len;
  logic        loop;
  logic        start;
  logic        stop;
  logic [31:0] div_clk_count;
  logic        tone_en;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done;
  int          n_checks = 0;
  int          n_fail = 0;
  organ_note_sequencer #(.TICK_CYCLES(4)) dut (
    .inclk(inclk), .Reset_n(Reset_n), .note_sw(note_sw), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seq_len(seq_len), .loop(loop), .start(start), .stop(stop),
    .div_clk_count(div_clk_count), .tone_en(tone_en), .step_idx(step_idx), .busy(busy), .done(done)
  );
  always #5 inclk = ~inclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge inclk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic play(input string tag, input logic [31:0] cnt, input logic tone, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_count"}, div_clk_count, cnt);
      chk({tag, "_tone"}, {31'd0, tone_en}, {31'd0, tone});
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    Reset_n = 1'b0; note_sw = 8'h00; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    seq_len = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    #12;
    chk("rst_count", div_clk_count, 32'd0);
    chk("rst_tone", {31'd0, tone_en}, 32'd0);
    chk("rst_step", {28'd0, step_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    Reset_n = 1'b1;
    tick();
    note_sw = 8'b0010_1000;
    tick();
    chk("live_count", div_clk_count, 32'd35816);
    chk("live_tone", {31'd0, tone_en}, 32'd1);
    note_sw = 8'h00;
    tick();
    chk("live_off_tone", {31'd0, tone_en}, 32'd0);
    chk("live_off_hold", div_clk_count, 32'd35816);
    wr(4'd0, 8'h52);
    wr(4'd1, 8'h80);
    wr(4'd2, 8'h70);
    seq_len = 4'd2;
    pulse_start();
    chk("p_load0_busy", {31'd0, busy}, 32'd1);
    chk("p_load0_step", {28'd0, step_idx}, 32'd0);
    chk("p_load0_hold", div_clk_count, 32'd35816);
    tick();
    play("p_s0", 32'd28408, 1'b1, 12);
    chk("p_load1_step", {28'd0, step_idx}, 32'd1);
    chk("p_load1_hold", div_clk_count, 32'd28408);
    tick();
    play("p_s1", 32'd47800, 1'b0, 4);
    chk("p_load2_step", {28'd0, step_idx}, 32'd2);
    tick();
    play("p_s2", 32'd23900, 1'b1, 4);
    chk("p_done", {31'd0, done}, 32'd1);
    chk("p_end_busy", {31'd0, busy}, 32'd0);
    chk("p_end_tone", {31'd0, tone_en}, 32'd0);
    tick();
    chk("p_done_pulse", {31'd0, done}, 32'd0);
    loop = 1'b1;
    pulse_start();
    tick();
    play("l_s0", 32'd28408, 1'b1, 12);
    tick();
    play("l_s1", 32'd47800, 1'b0, 4);
    tick();
    play("l_s2", 32'd23900, 1'b1, 4);
    chk("l_wrap_step", {28'd0, step_idx}, 32'd0);
    chk("l_wrap_busy", {31'd0, busy}, 32'd1);
    chk("l_wrap_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("l_again_count", div_clk_count, 32'd28408);
    chk("l_again_tone", {31'd0, tone_en}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("l_stop_busy", {31'd0, busy}, 32'd0);
    chk("l_stop_tone", {31'd0, tone_en}, 32'd0);
    loop = 1'b0;
    pulse_start();
    tick();
    repeat (11) tick();
    chk("s_last_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s_busy", {31'd0, busy}, 32'd0);
    chk("s_tone", {31'd0, tone_en}, 32'd0);
    chk("s_step", {28'd0, step_idx}, 32'd0);
    chk("s_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("s_nodone2", {31'd0, done}, 32'd0);
    chk("s_idle2", {31'd0, busy}, 32'd0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ss_busy2", {31'd0, busy}, 32'd0);
    pulse_start();
    tick();
    wr(4'd1, 8'h30);
    repeat (11) tick();
    chk("w_load1_step", {28'd0, step_idx}, 32'd1);
    wr(4'd1, 8'h10);
    play("w_s1", 32'd35816, 1'b1, 4);
    chk("w_load2_step", {28'd0, step_idx}, 32'd2);
    tick();
    play("w_s2", 32'd23900, 1'b1, 4);
    chk("w_done", {31'd0, done}, 32'd1);
    pulse_start();
    tick();
    tick();
    chk("r_pre_busy", {31'd0, busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("r_count", div_clk_count, 32'd0);
    chk("r_tone", {31'd0, tone_en}, 32'd0);
    chk("r_step", {28'd0, step_idx}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    #3;
    Reset_n = 1'b1;
    tick();
    seq_len = 4'd0;
    pulse_start();
    chk("r_load_busy", {31'd0, busy}, 32'd1);
    tick();
    play("r_s0", 32'd47800, 1'b1, 4);
    chk("r_done_end", {31'd0, done}, 32'd1);
    chk("r_busy_end", {31'd0, busy}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/organ_note_sequencer.md
# organ_note_sequencer

Upstream control stage for the organ tone divider. Selects the divider count (`div_clk_count`) and tone gate (`tone_en`) for the divided-clock tone generator from two sources: live note switches when idle, or a 16-step stored pattern played at a fixed tick rate. Outputs are registered so the divider sees a glitch-free count. When `tone_en` is low, the divider is held in its reset state, so no tone sounds.

## Interface
- `TICK_CYCLES`, default 12_500_000: inclk cycles per duration tick (250 ms at 50 MHz); must be ≥ 1.
- `inclk`  in  1  system clock, 50 MHz.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `note_sw`  in  8  live note switches, bit0=Do … bit7=high Do; used only in IDLE.
- `wr_en`  in  1  pattern write strobe.
- `wr_addr`  in  4  pattern entry index.
- `wr_data`  in  8  entry: [7] rest, [6:4] note 0–7, [3:0] dur (dur+1 ticks).
- `seq_len`  in  4  index of last step played (steps 0..seq_len).
- `loop`  in  1  1 = restart at step 0 after the last step.
- `start`  in  1  single-cycle pulse, begin playback.
- `stop`  in  1  single-cycle pulse, abort playback.
- `div_clk_count`  out  32  count sent to the divider.
- `tone_en`  out  1  1 = tone sounding; the divider is held in reset when low.
- `step_idx`  out  4  current pattern step.
- `busy`  out  1  high in LOAD/PLAY.
- `done`  out  1  one-cycle pulse when non-looping playback completes.

## Operation
- Note table, fixed at 50 MHz, count = round(50e6/(2f))−1:
  - 0: 47800 (523 Hz)
  - 1: 42588 (587 Hz)
  - 2: 37935 (659 Hz)
  - 3: 35816 (698 Hz)
  - 4: 31927 (783 Hz)
  - 5: 28408 (880 Hz)
  - 6: 25328 (987 Hz)
  - 7: 23900 (1046 Hz)
- Pattern RAM: 16×8, cleared to 0 by reset, written on any cycle with `wr_en`. A read and a write to the same entry in the same cycle returns the old data.
- FSM states: IDLE, LOAD, PLAY.
  - IDLE: `tone_en` = |`note_sw`. `div_clk_count` = table entry of the lowest set bit. If `note_sw`=0, the count holds its last value.
  - IDLE → LOAD on `start` & !`stop`. `step_idx` ← 0.
  - LOAD (1 cycle): latches entry[`step_idx`], clears the tick and duration counters, then goes to PLAY. Outputs hold their previous values during LOAD.
  - PLAY, first cycle: `div_clk_count` = table[note]; `tone_en` = !rest.
    - `tick_cnt` counts 0..TICK_CYCLES−1 and wraps; each wrap increments `dur_cnt`.
    - Step ends in the cycle where `dur_cnt`==dur and `tick_cnt`==TICK_CYCLES−1.
  - At step end:
    - If `step_idx` < `seq_len`: `step_idx`+1, go to LOAD.
    - Else if `loop`: `step_idx` ← 0, go to LOAD.
    - Else: go to IDLE, `done` pulses, `tone_en` ← 0.
- `stop` in LOAD or PLAY: next cycle IDLE, `tone_en` ← 0, no `done`, `step_idx` holds. `stop` wins over a simultaneous step end.
- `start` while `busy` is ignored.
- Changes to `seq_len`/`loop` during playback are sampled at each step end.

## Timing
- Reset values: `div_clk_count`=0, `tone_en`=0, `step_idx`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- All outputs are registered.
- IDLE switch-to-output latency: 1 cycle.
- `start` at cycle t: LOAD at t+1, PLAY with new outputs visible at t+2. `busy`=1 from t+1.
- Each step occupies 1 + (dur+1)·TICK_CYCLES cycles.
- `done` and the IDLE transition appear the cycle after the final step end. `busy` drops in the same cycle.

## Test plan
1. Reset mid-PLAY (TICK_CYCLES=4) → all outputs return to their reset values immediately; the next `start` plays from step 0 with RAM cleared (note 0, dur 0 → count 47800 for 4 cycles).
2. IDLE: `note_sw`=8'b0010_1000 → one cycle later `div_clk_count`=35816, `tone_en`=1. `note_sw`=0 → `tone_en`=0, count holds 35816.
3. TICK_CYCLES=4, entries 0=8'h52, 1=8'h80, 2=8'h70, `seq_len`=2, `loop`=0, `start`:
   - step 0: 28408 for 12 cycles;
   - LOAD;
   - step 1: `tone_en`=0 for 4 cycles;
   - LOAD;
   - step 2: 23900 for 4 cycles;
   - then `done`=1 for one cycle, `busy`=0.
4. Same pattern with `loop`=1 → after step 2, `step_idx`=0 and 28408 again; `done` never asserts.
5. `stop` on the exact cycle step 0 ends → IDLE next cycle, `tone_en`=0, `step_idx`=0, no `done`. `start`+`stop` in the same cycle in IDLE → stays IDLE.
6. Write entry 1 during step 0 playback → the new value is played at step 1. Write the entry being loaded during its LOAD cycle → the old value is played.
